// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: synchronous FIFO controller for a dual-port asynchronous SRAM.
// The write side registers address/data/enable straight into the SRAM; the
// read side forces an SRAM refresh by changing mem_addr_r before every read
// and captures the result into a registered output head (out_data).
// Total capacity is RAM_DEPTH words in memory plus one in the head register.
module sram_fifo_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] mem_addr_w,
  output logic [DATA_WIDTH-1:0] mem_data_w,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr_r,
  input  logic [DATA_WIDTH-1:0] mem_data_r
);

  localparam int                RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HOLD
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_mem_used;   // slots allocated by accepted writes
  logic [ADDR_WIDTH:0]   r_mem_avail;  // slots whose write has been committed
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [ADDR_WIDTH-1:0] r_mem_addr_w;
  logic [DATA_WIDTH-1:0] r_mem_data_w;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr_r;

  logic w_accept;
  logic w_fetch;
  logic w_avail_nz;

  assign in_ready   = (r_mem_used < DEPTH_C);
  assign w_accept   = in_valid & in_ready;
  assign w_fetch    = (r_state == ST_FETCH);
  assign w_avail_nz = (r_mem_avail != '0);

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign count      = r_mem_used + (ADDR_WIDTH + 1)'(r_out_valid);
  assign mem_addr_w = r_mem_addr_w;
  assign mem_data_w = r_mem_data_w;
  assign mem_we     = r_mem_we;
  assign mem_addr_r = r_mem_addr_r;

  // Write port: register each accepted word into the SRAM for exactly one cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of block order.
    if (rst) begin
      r_mem_we     <= 1'b0;
      r_mem_addr_w <= '0;
      r_mem_data_w <= '0;
      r_wr_ptr     <= '0;
    end else if (w_accept) begin
      r_mem_we     <= 1'b1;
      r_mem_addr_w <= r_wr_ptr;
      r_mem_data_w <= in_data;
      r_wr_ptr     <= r_wr_ptr + 1'b1;
    end else begin
      r_mem_we     <= 1'b0;
    end
  end

  // Occupancy: allocation on accept, commit one edge after mem_we, release on FETCH.
  always_ff @(posedge clk) begin
    // NOTE: only the control registers are reset; the SRAM array lives outside
    // this block and keeps its contents, which is safe because mem_avail gates
    // every read to slots written since reset.
    if (rst) begin
      r_mem_used  <= '0;
      r_mem_avail <= '0;
    end else begin
      r_mem_used  <= r_mem_used + (ADDR_WIDTH + 1)'(w_accept)
                                - (ADDR_WIDTH + 1)'(w_fetch);
      r_mem_avail <= r_mem_avail + (ADDR_WIDTH + 1)'(r_mem_we)
                                 - (ADDR_WIDTH + 1)'(w_fetch);
    end
  end

  // Read FSM: present the address, capture the refreshed data, then hold the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_rd_ptr     <= '0;
      r_mem_addr_r <= '1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_avail_nz) begin
            r_mem_addr_r <= r_rd_ptr;
            r_state      <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          r_out_data   <= mem_data_r;
          r_out_valid  <= 1'b1;
          r_rd_ptr     <= r_rd_ptr + 1'b1;
          // Park away from the next read slot so the next fetch is a real change.
          r_mem_addr_r <= ~(r_rd_ptr + 1'b1);
          r_state      <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (w_avail_nz) begin
              r_mem_addr_r <= r_rd_ptr;
              r_state      <= ST_FETCH;
            end else begin
              r_state      <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: directed and randomized checks of sram_fifo_ctrl with a
// queue-based FIFO reference model and a behavioural asynchronous SRAM whose
// read data refreshes only when the read address changes.
module tb_sram_fifo_ctrl;

  localparam int DW    = 16;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW:0]   count;
  logic [AW-1:0] mem_addr_w;
  logic [DW-1:0] mem_data_w;
  logic          mem_we;
  logic [AW-1:0] mem_addr_r;
  logic [DW-1:0] mem_data_r;

  always #5 clk = ~clk;

  sram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .mem_addr_w(mem_addr_w),
    .mem_data_w(mem_data_w),
    .mem_we    (mem_we),
    .mem_addr_r(mem_addr_r),
    .mem_data_r(mem_data_r)
  );

  // Behavioural SRAM: level write while mem_we is high, read refreshed on address change only.
  logic [DW-1:0] sram [DEPTH];
  always @(posedge clk) if (mem_we) sram[mem_addr_w] <= mem_data_w;
  always @(mem_addr_r) mem_data_r = sram[mem_addr_r];

  int            errors = 0;
  int            checks = 0;
  int            cyc    = 0;
  int            n_pop  = 0;
  logic [DW-1:0] q [$];
  logic          acc;
  logic          hs;
  logic [DW-1:0] last_pop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; the model tracks accepts/handshakes and checks occupancy.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
    logic [31:0] exp_head;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    acc = v & in_ready;
    hs  = out_valid & r;
    if (hs) begin
      exp_head = (q.size() > 0) ? {16'h0, q[0]} : 32'hxxxxxxxx;
      check("pop_data", {16'h0, out_data}, exp_head);
      last_pop = out_data;
      n_pop++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (acc) q.push_back(d);
    if (hs && q.size() > 0) void'(q.pop_front());
    check("count", 32'(count), 32'(q.size()));
    if (q.size() < DEPTH)      check("in_ready_open", 32'(in_ready), 32'd1);
    if (q.size() == DEPTH + 1) check("in_ready_full", 32'(in_ready), 32'd0);
  endtask

  task automatic do_reset(input logic v);
    rst       = 1'b1;
    in_valid  = v;
    in_data   = 16'h0099;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    q.delete();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && q.size() > 0; i++) step(1'b0, 16'h0, 1'b1);
    check(tag, 32'(q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int            prev;
    int            idx;
    int            base;
    int            n_acc;
    logic          v;
    logic [AW-1:0] beef_addr;

    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    do_reset(1'b0);

    // Reset values.
    check("rst_in_ready",   32'(in_ready),   32'd1);
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_out_data",   32'(out_data),   32'd0);
    check("rst_count",      32'(count),      32'd0);
    check("rst_mem_we",     32'(mem_we),     32'd0);
    check("rst_mem_addr_w", 32'(mem_addr_w), 32'd0);
    check("rst_mem_data_w", 32'(mem_data_w), 32'd0);
    check("rst_mem_addr_r", 32'(mem_addr_r), 32'(DEPTH - 1));

    // Single word: one-cycle write at address 0, head valid after three edges.
    step(1'b1, 16'h1234, 1'b1);
    check("t1_we_hi",    32'(mem_we),     32'd1);
    check("t1_addr_w",   32'(mem_addr_w), 32'd0);
    check("t1_data_w",   32'(mem_data_w), 32'h1234);
    check("t1_ov_e0",    32'(out_valid),  32'd0);
    step(1'b0, 16'h0, 1'b1);
    check("t1_we_lo",    32'(mem_we),     32'd0);
    check("t1_ov_e1",    32'(out_valid),  32'd0);
    step(1'b0, 16'h0, 1'b1);
    check("t1_ov_e2",    32'(out_valid),  32'd0);
    step(1'b0, 16'h0, 1'b1);
    check("t1_ov_e3",    32'(out_valid),  32'd1);
    check("t1_out_data", 32'(out_data),   32'h1234);
    step(1'b0, 16'h0, 1'b1);
    check("t1_count0",   32'(count),      32'd0);
    check("t1_ov_done",  32'(out_valid),  32'd0);

    // Fill to RAM_DEPTH+1 with the consumer stalled.
    do_reset(1'b0);
    n_acc = 0;
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 16'(i), 1'b0);
      if (acc) n_acc++;
    end
    check("full_accepts",  32'(n_acc),     32'd5);
    check("full_count",    32'(count),     32'd5);
    check("full_in_ready", 32'(in_ready),  32'd0);
    check("full_head_vld", 32'(out_valid), 32'd1);
    check("full_head",     32'(out_data),  32'h0001);

    // Drain from full: one word per two cycles, in order.
    prev = -1;
    base = n_pop;
    for (int i = 0; i < 40 && q.size() > 0; i++) begin
      step(1'b0, 16'h0, 1'b1);
      if (hs) begin
        if (prev >= 0) check("pop_gap", 32'(cyc - prev), 32'd2);
        prev = cyc;
      end
    end
    check("drain_pops",  32'(n_pop - base), 32'd5);
    check("drain_empty", 32'(q.size()),     32'd0);
    check("drain_ov",    32'(out_valid),    32'd0);
    check("drain_count", 32'(count),        32'd0);

    // Random valid/ready stream across several pointer wraps.
    idx  = 0;
    base = n_pop;
    for (int i = 0; i < 400 && (idx < 12 || q.size() > 0); i++) begin
      v = (idx < 12) && ($urandom_range(0, 1) == 1);
      step(v, 16'h00A0 + 16'(idx), $urandom_range(0, 1) == 1);
      if (acc) idx++;
    end
    check("rand_all_in",  32'(idx),          32'd12);
    check("rand_all_out", 32'(n_pop - base), 32'd12);
    check("rand_empty",   32'(q.size()),     32'd0);

    // Reuse of a slot after a wrap must return the new data, not the stale word.
    do_reset(1'b0);
    step(1'b1, 16'hBEEF, 1'b0);
    beef_addr = mem_addr_w;
    drain("stale_drain1");
    for (int i = 0; i < DEPTH - 1; i++) step(1'b1, 16'h0011 + 16'(i), 1'b0);
    drain("stale_drain2");
    step(1'b1, 16'hCAFE, 1'b0);
    check("stale_same_addr", 32'(mem_addr_w), 32'(beef_addr));
    drain("stale_drain3");
    check("stale_data", 32'(last_pop), 32'hCAFE);

    // Reset in the middle of a write burst.
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 16'h0071 + 16'(i), 1'b0);
    check("mid_we_before", 32'(mem_we), 32'd1);
    do_reset(1'b1);
    check("mid_count",    32'(count),      32'd0);
    check("mid_ov",       32'(out_valid),  32'd0);
    check("mid_we",       32'(mem_we),     32'd0);
    check("mid_addr_r",   32'(mem_addr_r), 32'(DEPTH - 1));
    check("mid_in_ready", 32'(in_ready),   32'd1);
    step(1'b1, 16'h0055, 1'b1);
    drain("post_rst_drain");
    check("post_rst_data", 32'(last_pop), 32'h0055);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
- Synchronous FIFO controller that drives the team's dual-port asynchronous SRAM.
- Owns both ends of the memory: the write port (mem_addr_w, mem_data_w, mem_we) and the read port (mem_addr_r in, mem_data_r back).
- Presents valid/ready streaming interfaces on both sides.
- Used to buffer demodulated samples between receiver stages that run at different burst rates.

Parameters:
- DATA_WIDTH, 16, sample word width; must match the SRAM.
- ADDR_WIDTH, 8, SRAM address width; RAM_DEPTH = 1 << ADDR_WIDTH; ADDR_WIDTH >= 1.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  producer has a word.
- in_ready  out  1  controller can accept a word.
- in_data  in  DATA_WIDTH  producer word.
- out_valid  out  1  out_data holds the FIFO head.
- out_ready  in  1  consumer takes the head.
- out_data  out  DATA_WIDTH  head word, registered.
- count  out  ADDR_WIDTH+1  occupancy = mem_used + out_valid, range 0..RAM_DEPTH+1.
- mem_addr_w  out  ADDR_WIDTH  SRAM write address, registered.
- mem_data_w  out  DATA_WIDTH  SRAM write data, registered.
- mem_we  out  1  SRAM write enable, registered, level-sensitive at the SRAM.
- mem_addr_r  out  ADDR_WIDTH  SRAM read address, registered.
- mem_data_r  in  DATA_WIDTH  SRAM read data; combinational from the SRAM, refreshed only when mem_addr_r changes.

Behaviour:
- State: wr_ptr and rd_ptr (ADDR_WIDTH bits, wrap modulo RAM_DEPTH); mem_used (slots allocated, 0..RAM_DEPTH); mem_avail (slots committed, readable).
- Reset values, applied on the rst edge even mid-operation:
  - in_ready=1, out_valid=0, out_data=0, count=0.
  - mem_we=0, mem_addr_w=0, mem_data_w=0, mem_addr_r=all-ones.
  - Pointers and counters = 0; state IDLE.
  - Any in-flight write is abandoned. SRAM contents are not cleared.
- in_ready = (mem_used < RAM_DEPTH), combinational from registers.
- Write path:
  - On an accept edge (in_valid & in_ready): register mem_addr_w=wr_ptr, mem_data_w=in_data, mem_we=1; then wr_ptr++ and mem_used++.
  - With no accept, mem_we=0 on the next edge, and address/data hold their values.
  - Back-to-back accepts keep mem_we high while address/data change each cycle.
  - mem_avail++ on the edge after each mem_we=1 cycle (the write is committed).
- Read FSM (mem_addr_r must change before every read to force an SRAM refresh; park value = ~rd_ptr):
  - IDLE: if mem_avail>0, set mem_addr_r=rd_ptr and go to FETCH.
  - FETCH: capture out_data=mem_data_r, set out_valid=1, rd_ptr++, mem_used--, mem_avail--, mem_addr_r=~(new rd_ptr); go to HOLD.
  - HOLD: hold out_data stable while out_valid & !out_ready. On handshake, out_valid=0. Then, if mem_avail>0, set mem_addr_r=rd_ptr and go to FETCH; else go to IDLE.
- Latency and throughput:
  - Empty FIFO: accept at edge E0 gives out_valid=1 after edge E3 (3 cycles).
  - Sustained output rate is one word per 2 cycles.
  - Sustained input rate is one word per cycle until full.
- Simultaneous accept and FETCH in the same cycle: mem_used nets to no change; the mem_avail increment and decrement also net correctly.
- A read never targets an uncommitted slot, so no same-address read/write hazard exists.
- Full: mem_used==RAM_DEPTH forces in_ready=0. The FETCH edge frees a slot, and in_ready=1 in the following cycle.
- Total capacity is RAM_DEPTH+1 words (memory plus output register).
- in_valid while in_ready=0 is ignored; in_data need not be held by this block.

Test Plan:
- Reset, then write 0x1234 with out_ready=1 -> mem_we high 1 cycle at addr 0; out_valid after 3 edges with out_data=0x1234; count returns to 0.
- ADDR_WIDTH=2, out_ready=0, push 0x0001..0x0006 continuously -> 5 accepted (4 in SRAM + head 0x0001), in_ready=0, count=5; 0x0006 not accepted.
- From the full state, pop all with out_ready=1 -> order 0x0001..0x0005, one word per 2 cycles, count decrements to 0, out_valid=0 at end.
- ADDR_WIDTH=2, stream 12 words (0x00A0+i) with random in_valid/out_ready -> output order preserved across 3 pointer wraps; no loss or duplication.
- Write 0xBEEF, then 0xCAFE to the same address after a wrap while mem_addr_r is parked -> output is 0xCAFE, not stale 0xBEEF.
- Assert rst for 1 cycle with 3 words buffered and mem_we=1 -> next cycle: count=0, out_valid=0, mem_we=0, mem_addr_r=all-ones, in_ready=1.
